// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   Multi-digit packed-BCD down-counter used in countdown mode. It is loaded
//   with a BCD start value, decrements once per qualified tick while running,
//   borrows across digits, and pulses done for one cycle on reaching zero.
//
//   Optional build macro: AUTO_RELOAD_EN
//     When defined, expiry reloads the last loaded value and keeps running.
//     This only happens if that stored value is nonzero.
//
// Ports
//   clk        : system clock, all state updates on the rising edge
//   reset      : synchronous, active-high, clears all state
//   tick       : one-cycle count-enable pulse from the prescaler
//   load       : capture load_value (digits >9 clamped to 9) and go IDLE
//   load_value : packed BCD start value, digit 0 at [3:0]
//   start      : begin or resume counting (ignored when count is zero)
//   pause      : suspend counting while running
//   count      : current packed BCD value
//   running    : high while in RUN
//   done       : one-cycle pulse when a tick drives count to zero
//   expired    : high while in EXPIRED
module bcd_countdown_timer #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                done_q, done_d;
  logic                running_q, running_d;
  logic                expired_q, expired_d;
`ifdef AUTO_RELOAD_EN
  logic [4*DIGITS-1:0] reload_q, reload_d;
`endif

  logic [4*DIGITS-1:0] clamped;
  logic [4*DIGITS-1:0] dec_val;
  logic                borrow;

  // Clamp each incoming digit into the legal BCD range.
  always_comb begin
    clamped = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end
  end

  // Ripple-borrow decrement: a digit moves only when every lower digit is 0.
  always_comb begin
    dec_val = count_q;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = clamped;
      state_d = IDLE;
`ifdef AUTO_RELOAD_EN
      reload_d = clamped;
`endif
    end else if (pause && state_q == RUN) begin
      state_d = PAUSED;
    end else if (start && (state_q == IDLE || state_q == PAUSED)) begin
      if (count_q != '0) begin
        state_d = RUN;
      end
    end else if (tick && state_q == RUN) begin
      if (dec_val == '0) begin
        done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
        if (reload_q != '0) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = EXPIRED;
        end
`else
        count_d = '0;
        state_d = EXPIRED;
`endif
      end else begin
        count_d = dec_val;
      end
    end
    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      running_q <= running_d;
      expired_q <= expired_d;
`ifdef AUTO_RELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer
//   Table of one-cycle stimulus records with the outputs expected after the
//   clock edge that samples them. Expected values are queued when the record
//   is driven and checked one edge later.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        reset, tick, load, start, pause;
  logic [15:0] load_value;
  logic [15:0] count;
  logic        running, done, expired;

  bcd_countdown_timer #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_value(load_value), .start(start), .pause(pause),
    .count(count), .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ld, st, pa, tk;
    logic [15:0] lv;
    logic [15:0] e_count;
    logic        e_run, e_done, e_exp;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] e_count;
    logic        e_run, e_done, e_exp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input logic rst, input logic ld, input logic [15:0] lv,
                              input logic st, input logic pa, input logic tk,
                              input logic [15:0] ec, input logic er,
                              input logic ed, input logic ee);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.tk = tk;
    v.e_count = ec; v.e_run = er; v.e_done = ed; v.e_exp = ee;
    vecs.push_back(v);
  endfunction

  // Idle cycle helper: no inputs asserted.
  function automatic void idle(input logic [15:0] ec, input logic er, input logic ee);
    add(0, 0, 16'h0, 0, 0, 0, ec, er, 1'b0, ee);
  endfunction

  // Checker: compares one edge after each record was driven.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (count !== e.e_count || running !== e.e_run ||
          done !== e.e_done || expired !== e.e_exp) begin
        bad++;
        $display("FAIL vec%0d: got count=%h run=%b done=%b exp=%b, want count=%h run=%b done=%b exp=%b",
                 e.idx, count, running, done, expired,
                 e.e_count, e.e_run, e.e_done, e.e_exp);
      end
    end
  end

  initial begin
    reset = 1; tick = 0; load = 0; start = 0; pause = 0; load_value = '0;

    // Reset state, start with count zero is ignored
    add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 0);
    idle(16'h0000, 0, 0);
    add(0, 0, 16'h0, 1, 0, 1, 16'h0000, 0, 0, 0);

    // Clamp
    add(0, 1, 16'h0A5F, 0, 0, 0, 16'h0959, 0, 0, 0);

    // Borrow chain
    add(0, 1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0);
    add(0, 0, 16'h0, 1, 0, 0, 16'h1000, 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0999, 1, 0, 0);
    idle(16'h0999, 1, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0998, 1, 0, 0);

    // Reset held two cycles mid-RUN
    add(1, 0, 16'h0, 0, 0, 1, 16'h0000, 0, 0, 0);
    add(1, 0, 16'h0, 1, 0, 1, 16'h0000, 0, 0, 0);
    idle(16'h0000, 0, 0);

    // Middle-digit borrow, tick outside RUN ignored
    add(0, 1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0100, 0, 0, 0);
    add(0, 0, 16'h0, 1, 0, 1, 16'h0100, 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0099, 1, 0, 0);

    // Pause with tick, resume, load overriding start and tick
    add(0, 1, 16'h0051, 0, 0, 0, 16'h0051, 0, 0, 0);
    add(0, 0, 16'h0, 1, 0, 0, 16'h0051, 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0050, 1, 0, 0);
    add(0, 0, 16'h0, 0, 1, 1, 16'h0050, 0, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0050, 0, 0, 0);
    add(0, 0, 16'h0, 1, 0, 0, 16'h0050, 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0049, 1, 0, 0);
    add(0, 1, 16'h0030, 1, 0, 1, 16'h0030, 0, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0030, 0, 0, 0);

`ifdef AUTO_RELOAD_EN
    // Auto reload: 2,1,3,2,1,3 with done on ticks 3 and 6
    add(0, 1, 16'h0003, 0, 0, 0, 16'h0003, 0, 0, 0);
    add(0, 0, 16'h0, 1, 0, 0, 16'h0003, 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0002, 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0001, 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0003, 1, 1, 0);
    idle(16'h0003, 1, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0002, 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0001, 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0003, 1, 1, 0);
    idle(16'h0003, 1, 0);
`else
    // Expiry, then start and ticks ignored in EXPIRED
    add(0, 1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0);
    add(0, 0, 16'h0, 1, 0, 0, 16'h0002, 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0001, 1, 0, 0);
    idle(16'h0001, 1, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0000, 0, 1, 1);
    idle(16'h0000, 0, 1);
    add(0, 0, 16'h0, 1, 0, 0, 16'h0000, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 16'h0, 0, 0, 1, 16'h0000, 0, 0, 1);
    // Load leaves EXPIRED, expire again across a borrow
    add(0, 1, 16'h0010, 0, 0, 0, 16'h0010, 0, 0, 0);
    add(0, 0, 16'h0, 1, 0, 0, 16'h0010, 1, 0, 0);
    for (int i = 9; i >= 1; i--) add(0, 0, 16'h0, 0, 0, 1, 16'(i), 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h0000, 0, 1, 1);
    idle(16'h0000, 0, 1);
`endif

    // Load while running returns to IDLE
    add(0, 1, 16'h9999, 0, 0, 0, 16'h9999, 0, 0, 0);
    add(0, 0, 16'h0, 1, 0, 0, 16'h9999, 1, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 16'h9998, 1, 0, 0);
    add(0, 1, 16'h0FFF, 0, 1, 1, 16'h0999, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(negedge clk);
      reset = vecs[i].rst; load = vecs[i].ld; load_value = vecs[i].lv;
      start = vecs[i].st;  pause = vecs[i].pa; tick = vecs[i].tk;
      e.idx = i; e.e_count = vecs[i].e_count; e.e_run = vecs[i].e_run;
      e.e_done = vecs[i].e_done; e.e_exp = vecs[i].e_exp;
      sb.push_back(e);
    end
    @(negedge clk);
    reset = 0; load = 0; start = 0; pause = 0; tick = 0;
    repeat (3) @(negedge clk);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Multi-digit BCD down-counter for countdown mode. It is the count-down counterpart of the stopwatch's cascaded mod-10 up-count digits. The block is loaded with a BCD start value and decrements once per qualified tick, borrowing across digits. On reaching zero it raises a one-cycle done pulse. It sits between the tick prescaler and the 7-segment display mux, and uses the same packed BCD digit format as the stopwatch counters.

Parameters:
DIGITS, 4, number of BCD digits; digit 0 is least significant, at bits [3:0].

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
tick  input  1  one-cycle count-enable pulse from prescaler
load  input  1  capture load_value into count
load_value  input  4*DIGITS  packed BCD start value
start  input  1  begin or resume counting
pause  input  1  suspend counting
count  output  4*DIGITS  current packed BCD value
running  output  1  high while in RUN state
done  output  1  one-cycle pulse when count reaches zero
expired  output  1  level; high while in EXPIRED state

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset, sampled only at the rising edge of clk.
- Reset values: count=0, running=0, done=0, expired=0, state=IDLE, reload register=0.
- FSM states are IDLE, RUN, PAUSED, EXPIRED. All outputs are registered.
- Input priority each cycle: reset > load > pause > start > tick.
- load, from any state:
  - count <= load_value, with each digit >9 clamped to 9.
  - Clamped value is also stored in the reload register.
  - State -> IDLE; done=0 that cycle; any start or tick in the same cycle is ignored.
- start:
  - From IDLE or PAUSED with count != 0: state -> RUN.
  - When count == 0: ignored, and done does not pulse.
  - In RUN or EXPIRED: no effect.
- pause in RUN: state -> PAUSED, and a tick in the same cycle is ignored. In other states pause has no effect.
- tick in RUN, latency 1 cycle (tick sampled at edge N, new count visible after edge N):
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - A digit decrements only if every lower digit is 0.
- Expiry: when the tick-driven decrement produces all-zero:
  - count=0, done=1 for exactly that one cycle, state -> EXPIRED, all in the same registered update.
- tick outside RUN: ignored; count holds.
- EXPIRED holds count=0 until load or reset. start is ignored there.
- Width: DIGITS*4 bits throughout; no binary conversion; no digit ever holds a value >9.
- A reset asserted mid-count overrides everything that cycle.

Optional Feature:
Macro AUTO_RELOAD_EN.
- Defined, at expiry:
  - count <= reload register instead of staying at 0, and state stays RUN.
  - done still pulses for one cycle; expired stays 0.
  - If the reload register is 0, behave as if the macro were undefined (enter EXPIRED).
- Undefined: behaviour exactly as in Behaviour; the reload register may be optimised away.

Test Plan:
- Reset: assert reset 2 cycles mid-RUN -> count=0000, running=0, done=0, expired=0 on the next cycle.
- Borrow chain: load 0x1000, start, 1 tick -> count=0x0999 one cycle after the tick, running=1.
- Clamp: load 0x0A5F -> count=0x0959.
- Expiry: load 0x0002, start, 2 ticks -> after the second tick count=0x0000, done=1 for exactly 1 cycle, expired=1, running=0. A further start and 5 ticks leave count at 0x0000.
- Simultaneous events:
  - In RUN at 0x0050, pause and tick in the same cycle -> count stays 0x0050, state PAUSED.
  - load 0x0030 with start and tick in the same cycle -> count=0x0030, state IDLE.
- AUTO_RELOAD_EN defined: load 0x0003, start, 6 ticks -> count sequence 2,1,3,2,1,3; done pulses on ticks 3 and 6; running stays 1; expired stays 0.
